// File: rtl/sd_deser_pkg.sv
// sd_deser_pkg: shared state encoding and CRC16 helpers for the SD lane deserializer.
`default_nettype none

package sd_deser_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_START = 3'd1,
        SHIFT      = 3'd2,
        CRC        = 3'd3,
        STOP       = 3'd4
    } state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int          CRC_BEATS  = 16;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_crc16_lane.sv
// sd_crc16_lane: serial CRC16 (x^16+x^12+x^5+1, seed 0) for a single SD data line.
`default_nettype none

module sd_crc16_lane
    import sd_deser_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clear_i) begin
            crc_q <= '0;
        end else if (en_i) begin
            crc_q <= crc16_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule

`default_nettype wire

// File: rtl/sd_lane_deserializer.sv
// sd_lane_deserializer: multi-lane SD DAT receive deserializer with valid/ready word output.
// Optional per-lane CRC16 check enabled by defining SD_DESER_CRC_CHECK_EN.
`default_nettype none

module sd_lane_deserializer
    import sd_deser_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = 10,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic                 arm_i,
    input  logic [CNT_W-1:0]     frame_words_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    input  logic [LANES-1:0]     in_i,
    output logic [WORD_W-1:0]    data_out_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_overrun_o,
    output logic                 err_stop_o,
`ifdef SD_DESER_CRC_CHECK_EN
    output logic                 crc_err_o,
`endif
    output logic                 err_timeout_o
);

    localparam int BEATS  = WORD_W / LANES;
    localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    state_e               state_q, state_d;
    logic [WORD_W-1:0]    sr_q, sr_d;
    logic [WORD_W-1:0]    dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 stp_q, stp_d;
    logic                 tmo_q, tmo_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [CNT_W-1:0]     wcnt_q, wcnt_d;
    logic [CNT_W-1:0]     fw_q, fw_d;
    // Start-bit timeout counter; also counts CRC beats when the CRC check is built in.
    logic [TIMEOUT_W-1:0] tmr_q, tmr_d;
    logic [TIMEOUT_W-1:0] to_q, to_d;
    logic [WORD_W-1:0]    word_c;

`ifdef SD_DESER_CRC_CHECK_EN
    logic             crc_err_q, crc_err_d;
    logic             crc_clr, crc_en;
    logic [LANES-1:0] crc_bad;

    for (genvar g = 0; g < LANES; g++) begin : g_crc_lane
        logic [15:0] lane_crc;
        sd_crc16_lane u_crc (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear_i (crc_clr),
            .en_i    (crc_en),
            .bit_i   (in_i[g]),
            .crc_o   (lane_crc)
        );
        // Feeding the received CRC through the same divider leaves zero on a match.
        assign crc_bad[g] = |lane_crc;
    end

    assign crc_err_o = crc_err_q;
`endif

    assign word_c = WORD_W'({sr_q, in_i});

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        stp_d   = stp_q;
        tmo_d   = tmo_q;
        bcnt_d  = bcnt_q;
        wcnt_d  = wcnt_q;
        fw_d    = fw_q;
        tmr_d   = tmr_q;
        to_d    = to_q;
`ifdef SD_DESER_CRC_CHECK_EN
        crc_err_d = crc_err_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
`endif
        if (enable_i) begin
            if (valid_q && data_ready_i) begin
                valid_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        fw_d    = frame_words_i;
                        to_d    = timeout_i;
                        ovr_d   = 1'b0;
                        stp_d   = 1'b0;
                        tmo_d   = 1'b0;
                        tmr_d   = '0;
                        bcnt_d  = '0;
                        wcnt_d  = '0;
                        state_d = WAIT_START;
`ifdef SD_DESER_CRC_CHECK_EN
                        crc_err_d = 1'b0;
                        crc_clr   = 1'b1;
`endif
                    end
                end
                WAIT_START: begin
                    if (in_i == '0) begin
                        state_d = SHIFT;
                    end else if (tmr_q + 1'b1 == to_q) begin
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                SHIFT: begin
                    sr_d   = word_c;
                    bcnt_d = bcnt_q + 1'b1;
`ifdef SD_DESER_CRC_CHECK_EN
                    crc_en = 1'b1;
`endif
                    if (bcnt_q == BCNT_W'(BEATS - 1)) begin
                        bcnt_d  = '0;
                        dout_d  = word_c;
                        valid_d = 1'b1;
                        if (valid_q && !data_ready_i) begin
                            ovr_d = 1'b1;
                        end
                        if (wcnt_q == fw_q) begin
                            tmr_d = '0;
`ifdef SD_DESER_CRC_CHECK_EN
                            state_d = CRC;
`else
                            state_d = STOP;
`endif
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
`ifdef SD_DESER_CRC_CHECK_EN
                CRC: begin
                    crc_en = 1'b1;
                    tmr_d  = tmr_q + 1'b1;
                    if (tmr_q == TIMEOUT_W'(CRC_BEATS - 1)) begin
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    if (in_i != '1) begin
                        stp_d = 1'b1;
                    end
`ifdef SD_DESER_CRC_CHECK_EN
                    crc_err_d = |crc_bad;
`endif
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            stp_q   <= 1'b0;
            tmo_q   <= 1'b0;
            bcnt_q  <= '0;
            wcnt_q  <= '0;
            fw_q    <= '0;
            tmr_q   <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            stp_q   <= stp_d;
            tmo_q   <= tmo_d;
            bcnt_q  <= bcnt_d;
            wcnt_q  <= wcnt_d;
            fw_q    <= fw_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
        end
    end

`ifdef SD_DESER_CRC_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_err_q <= 1'b0;
        end else begin
            crc_err_q <= crc_err_d;
        end
    end
`endif

    assign data_out_o    = dout_q;
    assign data_valid_o  = valid_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign err_overrun_o = ovr_q;
    assign err_stop_o    = stp_q;
    assign err_timeout_o = tmo_q;

endmodule

`default_nettype wire

// File: doc/sd_lane_deserializer.md
Name: sd_lane_deserializer

Overview:
- Streaming, multi-lane successor of the single-line SD deserializer, used in the SD host data path for the DAT[LANES-1:0] receive direction.
- Waits for the start bit, then shifts in LANES bits per clk. Emits WORD_W-bit words through a valid/ready register, then checks the end bit.
- Frame length is programmable per transaction; idles between frames without a reset.

Parameters:
- LANES, 4, number of serial data lines (1 or 4); WORD_W must be a multiple of LANES
- WORD_W, 8, output word width in bits
- CNT_W, 10, width of frame_words and the word counter
- TIMEOUT_W, 16, width of the start-bit timeout counter

Ports:
- clk  input  1  serial bit clock, all sampling on posedge
- reset  input  1  asynchronous, active-low; clears all state and outputs
- enable  input  1  low suspends: state, counters and shift register hold; no sampling
- arm  input  1  one-cycle pulse that begins a frame; ignored unless IDLE
- frame_words  input  CNT_W  number of words in frame minus 1; sampled on arm
- timeout  input  TIMEOUT_W  max cycles in WAIT_START; sampled on arm
- in  input  LANES  serial data, lane LANES-1 carries the most significant bit of each beat
- data_out  output  WORD_W  completed word
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse at frame end, with status valid
- err_overrun  output  1  a word completed while the previous word was still unconsumed
- err_stop  output  1  end beat was not all ones
- err_timeout  output  1  no start bit within timeout cycles

Behaviour:
- Reset (reset low, asynchronous): state IDLE; data_out=0, data_valid=0, busy=0, done=0, all err_*=0, counters=0.
- States: IDLE -> WAIT_START -> SHIFT -> (CRC) -> STOP -> IDLE. All transitions are gated by enable.
- IDLE: on arm, latch frame_words and timeout, clear err_*, go WAIT_START.
- WAIT_START:
  - in==0 on all lanes -> SHIFT; the first data beat is sampled on the next clk.
  - Any lane low while others are high counts as not started.
  - Timeout counter reaching the latched timeout -> set err_timeout, pulse done, go IDLE.
- SHIFT:
  - Each clk: sr <= {sr[WORD_W-LANES-1:0], in}.
  - After WORD_W/LANES beats: data_out <= word, data_valid <= 1.
  - If data_valid was 1 and data_ready was 0 in that cycle, set err_overrun (sticky to frame end) and overwrite data_out anyway. The bus cannot stall.
  - valid&&ready in the same cycle a new word lands is not an overrun.
  - After word index == latched frame_words, go CRC if CRC_CHECK_EN is defined, else STOP.
- data_valid clears on valid&&ready unless a new word lands in the same cycle.
- STOP: sample one beat. If in != all ones, set err_stop. Pulse done, go IDLE.
  - Latency from the last data beat to done: 1 clk without CRC, 17 clk with CRC.
- The word counter is CNT_W wide and never wraps. frame_words = 2^CNT_W-1 is the maximum frame.
- arm while busy is ignored. enable low in any state freezes everything, including the timeout count.
- Reset asserted mid-frame aborts immediately; no done pulse.

Optional Feature:
- Macro SD_DESER_CRC_CHECK_EN.
- When defined:
  - CRC state: 16 beats of per-lane CRC16 (polynomial 0x1021, seed 0) computed over the data bits of each lane.
  - Each lane's received 16 bits are compared with its computed CRC.
  - Extra output crc_err (1 bit, reset 0), set on any lane mismatch and valid with done.
- When undefined: no CRC state, no crc_err port, STOP directly follows SHIFT.

Decomposition:
- Package sd_deser_pkg: state enum (IDLE, WAIT_START, SHIFT, CRC, STOP), CRC16_POLY=16'h1021, CRC_BEATS=16, function crc16_step(crc, bit).
- Sub-module sd_crc16_lane: serial CRC16 for one lane, with clear and enable inputs. Instantiated LANES times, only under the macro.

Test Plan:
- LANES=4, WORD_W=8, frame_words=1, data_ready=1. Drive start 0x0, then nibbles 0xA,0x5,0x3,0xC, then stop 0xF -> words 0xA5 then 0x3C, done 1 clk after stop beat, all err_* 0.
- Same frame with data_ready=0 throughout -> data_out=0x3C, err_overrun=1 at done.
- Stop beat 0xE -> err_stop=1, done pulses, busy returns 0 the next clk.
- timeout=5, in held 0xF -> err_timeout=1 and done exactly 5 enable cycles after arm.
- enable low for 3 clks mid-word -> output words unchanged vs. the reference case; reset low mid-SHIFT -> all outputs 0 immediately.
- With SD_DESER_CRC_CHECK_EN: correct per-lane CRC16 -> crc_err=0; flip one CRC bit on lane 2 -> crc_err=1.
